histogram_peak_locator: RTL

Downstream consumer of the histogram stage: on `start` it requests the X and Y projection histograms, scans both 256-bin streams as they arrive, and reports per-axis peak bin, peak count and the occupied span (first/last bin at or above a threshold). The result is a registered bounding box plus `objectFound`, held under a valid/ready handshake for the tracking/control logic that wakes the rest of the system.

---
 rtl/histogram_peak_locator_pkg.sv | 16 +
 rtl/axis_hist_scan.sv | 111 +++++++++++
 rtl/histogram_peak_locator.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/histogram_peak_locator_pkg.sv
// Shared constants and FSM state type for the histogram peak locator.
package hist_peak_pkg;

  localparam int DEF_NUM_BINS       = 256;
  localparam int DEF_COUNT_W        = 8;
  localparam int BIN_W              = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/axis_hist_scan.sv
// Per-axis histogram scanner: beat counter, running peak/argmax and occupied span.
// Exposes next-state values so the top can capture the result on the final beat's edge.
module axis_hist_scan
  import hist_peak_pkg::*;
#(
  parameter int NUM_BINS = DEF_NUM_BINS,
  parameter int COUNT_W  = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [COUNT_W-1:0] i_count,
  input  logic [COUNT_W-1:0] i_threshold,
  output logic [BIN_W-1:0]   o_peak_next,
  output logic [COUNT_W-1:0] o_peak_count_next,
  output logic [BIN_W-1:0]   o_min_next,
  output logic [BIN_W-1:0]   o_max_next,
  output logic               o_axis_found,
  output logic               o_axis_done,
  output logic               o_accept
);

  localparam int CNT_W = $clog2(NUM_BINS + 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_peak;
  logic [COUNT_W-1:0] r_peak_count;
  logic [BIN_W-1:0]   r_min;
  logic [BIN_W-1:0]   r_max;
  logic               r_found;

  logic [CNT_W-1:0]   w_cnt_n;
  logic [BIN_W-1:0]   w_peak_n;
  logic [COUNT_W-1:0] w_peak_count_n;
  logic [BIN_W-1:0]   w_min_n;
  logic [BIN_W-1:0]   w_max_n;
  logic               w_found_n;
  logic               w_accept;
  logic [BIN_W-1:0]   w_idx;

  // Strict '>' keeps the lowest bin on ties; Min latches only on the first occupied bin.
  always_comb begin
    w_accept       = i_enable && i_valid && (r_cnt < CNT_W'(NUM_BINS));
    w_idx          = BIN_W'(r_cnt);
    w_cnt_n        = r_cnt;
    w_peak_n       = r_peak;
    w_peak_count_n = r_peak_count;
    w_min_n        = r_min;
    w_max_n        = r_max;
    w_found_n      = r_found;
    if (i_clear) begin
      w_cnt_n        = '0;
      w_peak_n       = '0;
      w_peak_count_n = '0;
      w_min_n        = '0;
      w_max_n        = '0;
      w_found_n      = 1'b0;
    end else if (w_accept) begin
      w_cnt_n = r_cnt + CNT_W'(1);
      if (i_count > r_peak_count) begin
        w_peak_count_n = i_count;
        w_peak_n       = w_idx;
      end else begin
        w_peak_count_n = r_peak_count;
      end
      if (i_count >= i_threshold) begin
        if (!r_found) begin
          w_min_n = w_idx;
        end else begin
          w_min_n = r_min;
        end
        w_max_n   = w_idx;
        w_found_n = 1'b1;
      end else begin
        w_found_n = r_found;
      end
    end else begin
      w_cnt_n = r_cnt;
    end
  end

  assign o_peak_next       = w_peak_n;
  assign o_peak_count_next = w_peak_count_n;
  assign o_min_next        = w_min_n;
  assign o_max_next        = w_max_n;
  assign o_axis_found      = w_found_n;
  assign o_axis_done       = (w_cnt_n == CNT_W'(NUM_BINS));
  assign o_accept          = w_accept;

  // Scanner state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_peak       <= '0;
      r_peak_count <= '0;
      r_min        <= '0;
      r_max        <= '0;
      r_found      <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_n;
      r_peak       <= w_peak_n;
      r_peak_count <= w_peak_count_n;
      r_min        <= w_min_n;
      r_max        <= w_max_n;
      r_found      <= w_found_n;
    end
  end

endmodule

// File: rtl/histogram_peak_locator.sv
// Requests X/Y projection histograms, scans them and holds a registered bounding box.
// Optional COLLECT watchdog and timeoutErr port enabled by HIST_PEAK_TIMEOUT_EN.
module histogram_peak_locator
  import hist_peak_pkg::*;
#(
  parameter int NUM_BINS       = DEF_NUM_BINS,
`ifdef HIST_PEAK_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
  parameter int COUNT_W        = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] binThreshold,
  output logic               readHistogram,
  input  logic [COUNT_W-1:0] xHistogramIn,
  input  logic               xValid,
  input  logic [COUNT_W-1:0] yHistogramIn,
  input  logic               yValid,
  output logic [BIN_W-1:0]   xPeak,
  output logic [BIN_W-1:0]   yPeak,
  output logic [COUNT_W-1:0] xPeakCount,
  output logic [COUNT_W-1:0] yPeakCount,
  output logic [BIN_W-1:0]   xMin,
  output logic [BIN_W-1:0]   xMax,
  output logic [BIN_W-1:0]   yMin,
  output logic [BIN_W-1:0]   yMax,
  output logic               objectFound,
  output logic               resultValid,
  input  logic               resultReady,
`ifdef HIST_PEAK_TIMEOUT_EN
  output logic               timeoutErr,
`endif
  output logic               busy
);

  state_e             r_state;
  logic [COUNT_W-1:0] r_thr;
  logic               r_read, r_busy, r_valid, r_found;
  logic [BIN_W-1:0]   r_x_peak, r_y_peak, r_x_min, r_x_max, r_y_min, r_y_max;
  logic [COUNT_W-1:0] r_x_pc, r_y_pc;

  logic               w_clear, w_enable, w_timeout;
  logic [BIN_W-1:0]   w_x_peak, w_y_peak, w_x_min, w_x_max, w_y_min, w_y_max;
  logic [COUNT_W-1:0] w_x_pc, w_y_pc;
  logic               w_x_found, w_y_found, w_x_done, w_y_done, w_x_acc, w_y_acc;

  assign w_clear  = (r_state == ST_REQUEST);
  assign w_enable = (r_state == ST_COLLECT);

  axis_hist_scan #(.NUM_BINS(NUM_BINS), .COUNT_W(COUNT_W)) u_x_scan (
    .clk(clk), .reset(reset), .i_clear(w_clear), .i_enable(w_enable),
    .i_valid(xValid), .i_count(xHistogramIn), .i_threshold(r_thr),
    .o_peak_next(w_x_peak), .o_peak_count_next(w_x_pc), .o_min_next(w_x_min),
    .o_max_next(w_x_max), .o_axis_found(w_x_found), .o_axis_done(w_x_done),
    .o_accept(w_x_acc)
  );

  axis_hist_scan #(.NUM_BINS(NUM_BINS), .COUNT_W(COUNT_W)) u_y_scan (
    .clk(clk), .reset(reset), .i_clear(w_clear), .i_enable(w_enable),
    .i_valid(yValid), .i_count(yHistogramIn), .i_threshold(r_thr),
    .o_peak_next(w_y_peak), .o_peak_count_next(w_y_pc), .o_min_next(w_y_min),
    .o_max_next(w_y_max), .o_axis_found(w_y_found), .o_axis_done(w_y_done),
    .o_accept(w_y_acc)
  );

`ifdef HIST_PEAK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_timeout_err;

  assign w_timeout  = w_enable && !(w_x_acc || w_y_acc) && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeoutErr = r_timeout_err;

  // Idle-cycle watchdog for COLLECT and its sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
      if (!w_enable || w_x_acc || w_y_acc) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + WD_W'(1);
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Control FSM and result registers; results capture the scanners' next values on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_thr    <= '0;
      r_read   <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_found  <= 1'b0;
      r_x_peak <= '0;
      r_y_peak <= '0;
      r_x_pc   <= '0;
      r_y_pc   <= '0;
      r_x_min  <= '0;
      r_x_max  <= '0;
      r_y_min  <= '0;
      r_y_max  <= '0;
    end else begin
      r_read <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_REQUEST;
            r_read  <= 1'b1;
            r_busy  <= 1'b1;
            r_thr   <= binThreshold;
          end
        end
        ST_REQUEST: begin
          r_state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (w_x_done && w_y_done) begin
            r_state  <= ST_DONE;
            r_valid  <= 1'b1;
            r_found  <= w_x_found && w_y_found;
            r_x_peak <= w_x_peak;
            r_y_peak <= w_y_peak;
            r_x_pc   <= w_x_pc;
            r_y_pc   <= w_y_pc;
            r_x_min  <= w_x_min;
            r_x_max  <= w_x_max;
            r_y_min  <= w_y_min;
            r_y_max  <= w_y_max;
          end else if (w_timeout) begin
            r_state  <= ST_DONE;
            r_valid  <= 1'b1;
            r_found  <= 1'b0;
            r_x_peak <= '0;
            r_y_peak <= '0;
            r_x_pc   <= '0;
            r_y_pc   <= '0;
            r_x_min  <= '0;
            r_x_max  <= '0;
            r_y_min  <= '0;
            r_y_max  <= '0;
          end
        end
        ST_DONE: begin
          if (r_valid && resultReady) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign readHistogram = r_read;
  assign busy          = r_busy;
  assign resultValid   = r_valid;
  assign objectFound   = r_found;
  assign xPeak         = r_x_peak;
  assign yPeak         = r_y_peak;
  assign xPeakCount    = r_x_pc;
  assign yPeakCount    = r_y_pc;
  assign xMin          = r_x_min;
  assign xMax          = r_x_max;
  assign yMin          = r_y_min;
  assign yMax          = r_y_max;

endmodule
